// File: rtl/pbl_arb_defs.sv
// rtl/pbl_arb_defs.sv - shared state encoding, owner encoding and defaults for the two-requester arbiter
package pbl_arb_defs;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT1 = 2'd1,
        ST_GRANT2 = 2'd2,
        ST_TURN   = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWNER1 = 1'b0,
        OWNER2 = 1'b1
    } owner_e;

    localparam int unsigned DEFAULT_MAX_HOLD = 15;
    localparam int unsigned HOLD_W           = 4;

    // Decision taken from IDLE or TURN; the loser of a tie in round-robin is whoever held the bus last.
    function automatic arb_state_e arbitrate(
        input logic   req1,
        input logic   req2,
        input logic   priority_sel,
        input logic   use_priority,
        input owner_e last_owner
    );
        arb_state_e nxt;
        if (req1 && req2) begin
            if (use_priority) begin
                nxt = priority_sel ? ST_GRANT1 : ST_GRANT2;
            end else begin
                nxt = (last_owner == OWNER2) ? ST_GRANT1 : ST_GRANT2;
            end
        end else if (req1) begin
            nxt = ST_GRANT1;
        end else if (req2) begin
            nxt = ST_GRANT2;
        end else begin
            nxt = ST_IDLE;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/hold_counter.sv
// rtl/hold_counter.sv - 4-bit grant-length counter with load-to-one, increment and saturation at MAX
module hold_counter
    import pbl_arb_defs::*;
#(
    parameter int unsigned MAX = DEFAULT_MAX_HOLD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic inc,
    output logic at_max
);

    logic [HOLD_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= 4'd1;
        end else if (inc && (count != 4'(MAX))) begin
            count <= count + 4'd1;
        end
    end

    assign at_max = (count == 4'(MAX));

endmodule

// File: rtl/priority_arbiter.sv
// rtl/priority_arbiter.sv - two-requester bus arbiter with fixed-priority or round-robin mode and bounded hold time
module priority_arbiter
    import pbl_arb_defs::*;
#(
    parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req1,
    input  logic req2,
    input  logic priority_sel,
    input  logic use_priority,
    output logic grant1,
    output logic grant2,
    output logic ie1,
    output logic ie2,
    output logic busy
);

    arb_state_e state;
    arb_state_e state_next;
    owner_e     last_owner;
    logic       hold_load;
    logic       hold_inc;
    logic       hold_at_max;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Mode inputs only matter in IDLE/TURN, so flipping them mid-grant never preempts the owner.
    always_comb begin
        state_next = state;
        hold_load  = 1'b0;
        hold_inc   = 1'b0;
        case (state)
            ST_IDLE, ST_TURN: begin
                state_next = arbitrate(req1, req2, priority_sel, use_priority, last_owner);
                hold_load  = (state_next == ST_GRANT1) || (state_next == ST_GRANT2);
            end
            ST_GRANT1: begin
                if (!req1 || (req2 && hold_at_max)) begin
                    state_next = ST_TURN;
                end else begin
                    hold_inc = 1'b1;
                end
            end
            ST_GRANT2: begin
                if (!req2 || (req1 && hold_at_max)) begin
                    state_next = ST_TURN;
                end else begin
                    hold_inc = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Reset value OWNER2 makes the first round-robin tie go to requester 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_owner <= OWNER2;
        end else if (hold_load) begin
            last_owner <= (state_next == ST_GRANT1) ? OWNER1 : OWNER2;
        end
    end

    hold_counter #(
        .MAX (MAX_HOLD)
    ) u_hold_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (hold_load),
        .inc    (hold_inc),
        .at_max (hold_at_max)
    );

    assign grant1 = (state == ST_GRANT1);
    assign grant2 = (state == ST_GRANT2);
    assign ie1    = (state == ST_GRANT1);
    assign ie2    = (state == ST_GRANT2);
    assign busy   = (state == ST_GRANT1) || (state == ST_GRANT2);

endmodule

// File: tb/tb_priority_arbiter.sv
// tb/tb_priority_arbiter.sv - scoreboard bench for priority_arbiter with MAX_HOLD=4
module tb_priority_arbiter;

    localparam logic [4:0] O_NONE = 5'b00000;
    localparam logic [4:0] O_G1   = 5'b10101;
    localparam logic [4:0] O_G2   = 5'b01011;

    logic clk = 1'b0;
    logic rst_n;
    logic req1;
    logic req2;
    logic priority_sel;
    logic use_priority;
    logic grant1;
    logic grant2;
    logic ie1;
    logic ie2;
    logic busy;

    int total = 0;
    int bad   = 0;
    logic [4:0] exp_q[$];
    logic [4:0] got;
    logic [4:0] exp;

    priority_arbiter #(
        .MAX_HOLD (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req1         (req1),
        .req2         (req2),
        .priority_sel (priority_sel),
        .use_priority (use_priority),
        .grant1       (grant1),
        .grant2       (grant2),
        .ie1          (ie1),
        .ie2          (ie2),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic r1, input logic r2, input logic pr, input logic up, input logic rn);
        req1         = r1;
        req2         = r2;
        priority_sel = pr;
        use_priority = up;
        rst_n        = rn;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            exp_q.push_back(O_NONE);
            @(posedge clk);
            #1;
            got = {grant1, grant2, ie1, ie2, busy};
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL reset_hold[%0d] got=%b exp=%b", i, got, exp);
            end
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(O_G1);
        @(posedge clk);
        #1;
        got = {grant1, grant2, ie1, ie2, busy};
        exp = exp_q.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL reset_release got=%b exp=%b", got, exp);
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            exp_q.push_back(O_G2);
            @(posedge clk);
            #1;
            got = {grant1, grant2, ie1, ie2, busy};
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL fixed_priority[%0d] got=%b exp=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_rr_timeout();
        logic [4:0] seq [11] = '{O_G1, O_G1, O_G1, O_G1, O_NONE,
                                 O_G2, O_G2, O_G2, O_G2, O_NONE, O_G1};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            exp_q.push_back(seq[i]);
            @(posedge clk);
            #1;
            got = {grant1, grant2, ie1, ie2, busy};
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL rr_timeout[%0d] got=%b exp=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_no_competitor();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            exp_q.push_back(O_G1);
            @(posedge clk);
            #1;
            got = {grant1, grant2, ie1, ie2, busy};
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL no_competitor[%0d] got=%b exp=%b", i, got, exp);
            end
        end
        // Competitor arrives after saturation: hand-over must follow immediately.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(O_NONE);
        @(posedge clk);
        #1;
        got = {grant1, grant2, ie1, ie2, busy};
        exp = exp_q.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL saturated_handover got=%b exp=%b", got, exp);
        end
    endtask

    task automatic test_release();
        logic [4:0] seq [5] = '{O_G2, O_G2, O_G2, O_NONE, O_G1};
        logic       r2  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, r2[i], 1'b0, 1'b1, 1'b1);
            exp_q.push_back(seq[i]);
            @(posedge clk);
            #1;
            got = {grant1, grant2, ie1, ie2, busy};
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL release[%0d] got=%b exp=%b", i, got, exp);
            end
            total++;
            if ((ie1 & ie2) !== 1'b0) begin
                bad++;
                $display("FAIL ie_exclusive[%0d] ie1=%b ie2=%b exp=not both", i, ie1, ie2);
            end
        end
    endtask

    task automatic test_no_preempt();
        logic [4:0] seq [6] = '{O_G1, O_G1, O_G1, O_G1, O_NONE, O_G2};
        logic       pr  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, pr[i], 1'b1, 1'b1);
            exp_q.push_back(seq[i]);
            @(posedge clk);
            #1;
            got = {grant1, grant2, ie1, ie2, busy};
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL no_preempt[%0d] got=%b exp=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_midgrant_reset();
        logic [4:0] seq [6] = '{O_G1, O_NONE, O_G2, O_G2, O_NONE, O_G1};
        logic       up  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       rn  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic       r1  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(r1[i], 1'b1, 1'b0, up[i], rn[i]);
            exp_q.push_back(seq[i]);
            @(posedge clk);
            #1;
            got = {grant1, grant2, ie1, ie2, busy};
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL midgrant_reset[%0d] got=%b exp=%b", i, got, exp);
            end
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        test_reset();
        test_fixed_priority();
        test_rr_timeout();
        test_no_competitor();
        test_release();
        test_no_preempt();
        test_midgrant_reset();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
